// File: rtl/mod_pkg.sv
// Shared types and the sine-table generator for the bitstream modulator.
package mod_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK = 2'b00,
    MODE_OOK  = 2'b01,
    MODE_BFSK = 2'b10,
    MODE_RSVD = 2'b11
  } mod_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mod_state_t;

  localparam real TWO_PI = 6.283185307179586;

  // Entry k of a LUT_DEPTH-point sine table scaled to 2^(OUT_W-1)-1, rounded half away from zero.
  function automatic int sine_entry(input int k, input int depth, input int out_w);
    real amp;
    real x;
    amp = real'((1 << (out_w - 1)) - 1);
    x   = amp * $sin(TWO_PI * real'(k) / real'(depth));
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end else begin
      return -$rtoi(0.5 - x);
    end
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered sine ROM: one read per cycle, data valid the cycle after the address.
module sine_lut
  import mod_pkg::*;
#(
  parameter int LUT_DEPTH = 16,
  parameter int OUT_W     = 9
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$clog2(LUT_DEPTH)-1:0] addr_i,
  output logic signed [OUT_W-1:0]      data_o
);

  logic signed [OUT_W-1:0] rom_s [LUT_DEPTH];
  logic signed [OUT_W-1:0] data_q;

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam logic signed [OUT_W-1:0] ENTRY = OUT_W'(sine_entry(k, LUT_DEPTH, OUT_W));
    assign rom_s[k] = ENTRY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= {OUT_W{1'b0}};
    end else begin
      data_q <= rom_s[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bitstream_modulator.sv
// Serialises a latched payload MSB-first onto a LUT sine carrier (BPSK / OOK / BFSK).
// The ROM is addressed with next-cycle phase so its output always equals LUT[phase_q].
module bitstream_modulator
  import mod_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int OUT_W     = 9,
  parameter int LUT_DEPTH = 16,
  parameter int SPS       = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_W-1:0]               data_in,
  input  logic [$clog2(DATA_W+1)-1:0]     len,
  input  logic [1:0]                      mode,
  output logic                            busy,
  output logic                            done,
  output logic                            sample_valid,
  output logic signed [OUT_W-1:0]         mod_out,
  output logic                            in_data
);

  localparam int LEN_W = $clog2(DATA_W + 1);
  localparam int PH_W  = $clog2(LUT_DEPTH);
  localparam int SC_W  = (SPS > 1) ? $clog2(SPS) : 1;

  mod_state_t              state_q, state_d;
  logic [DATA_W-1:0]       sr_q, sr_d;
  logic [LEN_W-1:0]        len_q, len_d;
  mod_mode_t               mode_q, mode_d;
  logic [LEN_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SC_W-1:0]         samp_cnt_q, samp_cnt_d;
  logic [PH_W-1:0]         phase_q, phase_d;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    in_data_q, in_data_d;
  logic signed [OUT_W-1:0] mod_q, mod_d;

  logic                    cur_bit_s;
  logic [PH_W-1:0]         step_s;
  logic                    samp_end_s;
  logic                    last_s;
  logic [LEN_W-1:0]        len_clamp_s;
  logic signed [OUT_W-1:0] lut_data_s;
  logic signed [OUT_W-1:0] shaped_s;

  assign cur_bit_s   = sr_q[DATA_W-1];
  assign step_s      = (mode_q == MODE_BFSK && cur_bit_s) ? PH_W'(2) : PH_W'(1);
  assign samp_end_s  = (samp_cnt_q == SC_W'(SPS - 1));
  assign last_s      = samp_end_s && (bit_cnt_q == (len_q - LEN_W'(1)));
  assign len_clamp_s = (len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;

  sine_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .OUT_W     (OUT_W)
  ) u_sine_lut (
    .clk_i  (clk),
    .rst_ni (reset),
    .addr_i (phase_d),
    .data_o (lut_data_s)
  );

  // Next-state, capture and counter logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    len_d      = len_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    samp_cnt_d = samp_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d       = data_in;
          len_d      = len_clamp_s;
          mode_d     = mod_mode_t'(mode);
          bit_cnt_d  = {LEN_W{1'b0}};
          samp_cnt_d = {SC_W{1'b0}};
          phase_d    = {PH_W{1'b0}};
          state_d    = (len_clamp_s == {LEN_W{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + step_s;
        if (samp_end_s) begin
          samp_cnt_d = {SC_W{1'b0}};
          sr_d       = sr_q << 1;
          bit_cnt_d  = bit_cnt_q + LEN_W'(1);
          state_d    = last_s ? ST_DONE : ST_RUN;
        end else begin
          samp_cnt_d = samp_cnt_q + SC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit-to-carrier mapping; reserved mode falls back to BPSK
  always_comb begin
    shaped_s = lut_data_s;
    case (mode_q)
      MODE_OOK:  shaped_s = cur_bit_s ? lut_data_s : {OUT_W{1'b0}};
      MODE_BFSK: shaped_s = lut_data_s;
      default:   shaped_s = cur_bit_s ? lut_data_s : -lut_data_s;
    endcase
  end

  // Registered output values derived from the current state
  always_comb begin
    busy_d    = (state_q != ST_IDLE);
    done_d    = (state_q == ST_DONE);
    valid_d   = (state_q == ST_RUN);
    in_data_d = valid_d & cur_bit_s;
    mod_d     = valid_d ? shaped_s : {OUT_W{1'b0}};
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sr_q       <= {DATA_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      mode_q     <= MODE_BPSK;
      bit_cnt_q  <= {LEN_W{1'b0}};
      samp_cnt_q <= {SC_W{1'b0}};
      phase_q    <= {PH_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      in_data_q  <= 1'b0;
      mod_q      <= {OUT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      in_data_q  <= in_data_d;
      mod_q      <= mod_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = valid_q;
  assign in_data      = in_data_q;
  assign mod_out      = mod_q;

endmodule

// File: tb/tb_bitstream_modulator.sv
// Scoreboard bench for bitstream_modulator: frame-level reference model feeds queues, a monitor compares.
module tb_bitstream_modulator;

  localparam int DATA_W    = 64;
  localparam int OUT_W     = 9;
  localparam int LUT_DEPTH = 16;
  localparam int SPS       = 16;
  localparam int LEN_W     = $clog2(DATA_W + 1);
  localparam int AMP       = (1 << (OUT_W - 1)) - 1;
  localparam int PERIOD    = 10;
  localparam int BUDGET    = DATA_W * SPS + 40;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [DATA_W-1:0]       data_in = '0;
  logic [LEN_W-1:0]        len = '0;
  logic [1:0]              mode = 2'b00;
  logic                    busy, done, sample_valid, in_data;
  logic signed [OUT_W-1:0] mod_out;

  int  total = 0;
  int  bad = 0;
  int  popped = 0;
  int  ref_lut [LUT_DEPTH];
  int  exp_val [$];
  bit  exp_bit [$];
  time exp_done [$];

  bitstream_modulator #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .LUT_DEPTH(LUT_DEPTH), .SPS(SPS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .len(len), .mode(mode),
    .busy(busy), .done(done), .sample_valid(sample_valid), .mod_out(mod_out), .in_data(in_data)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Whole-frame waveform from the modulation rules: bits MSB-first, SPS samples each, running phase.
  task automatic push_frame(input logic [DATA_W-1:0] d, input int ln, input int md, input time t_acc);
    int l;
    int ph;
    l  = (ln > DATA_W) ? DATA_W : ln;
    ph = 0;
    for (int b = 0; b < l; b++) begin
      bit bv;
      bv = d[DATA_W-1-b];
      for (int s = 0; s < SPS; s++) begin
        int v;
        v = ref_lut[ph];
        case (md)
          1:       v = bv ? v : 0;
          2:       v = v;
          default: v = bv ? v : -v;
        endcase
        exp_val.push_back(v);
        exp_bit.push_back(bv);
        ph = (ph + ((md == 2 && bv) ? 2 : 1)) % LUT_DEPTH;
      end
    end
    exp_done.push_back(t_acc + time'((1 + l * SPS) * PERIOD));
  endtask

  task automatic flush();
    exp_val.delete();
    exp_bit.delete();
    exp_done.delete();
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int ln, input int md);
    @(negedge clk);
    data_in = d;
    len     = LEN_W'(ln);
    mode    = 2'(md);
    start   = 1'b1;
    @(posedge clk);
    push_frame(d, ln, md, $time);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      check("frame_timeout", 1, 0);
      flush();
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  // Monitor: pops one expected sample per valid cycle and one expected done per pulse
  always @(negedge clk) begin
    if (sample_valid) begin
      popped++;
      if (exp_val.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        check("mod_out", mod_out, exp_val.pop_front());
        check("in_data", in_data, exp_bit.pop_front());
        check("busy_in_frame", busy, 1);
      end
    end else begin
      check("idle_mod_out", mod_out, 0);
      check("idle_in_data", in_data, 0);
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("done_time", longint'($time), longint'(exp_done.pop_front() + PERIOD/2));
        check("busy_at_done", busy, 1);
        check("samples_left_at_done", exp_val.size(), 0);
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    int n;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      real x;
      x = real'(AMP) * $sin(6.283185307179586 * real'(k) / real'(LUT_DEPTH));
      ref_lut[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    end

    // Reset held while start toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      data_in = {$urandom, $urandom};
      len = LEN_W'(8);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", sample_valid, 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send(64'hABCD123789E3F456, 64, 0);
    wait_idle();
    send(64'h5000_0000_0000_0000, 4, 1);
    wait_idle();
    send(64'h8000_0000_0000_0000, 2, 2);
    wait_idle();
    send({$urandom, $urandom}, 0, 0);
    wait_idle();
    send({$urandom, $urandom}, 100, 3);
    wait_idle();

    // Start re-pulsed mid-frame is ignored
    send(64'hF0F0_1234_5678_9ABC, 8, 0);
    repeat (40) @(negedge clk);
    start = 1'b1;
    data_in = 64'h0123_4567_89AB_CDEF;
    len = LEN_W'(3);
    mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high through DONE: second frame accepted two cycles after the first ends
    @(negedge clk);
    d = 64'hC3A5_5A3C_0FF0_1234;
    data_in = d;
    len = LEN_W'(5);
    mode = 2'b00;
    start = 1'b1;
    @(posedge clk);
    push_frame(d, 5, 0, $time);
    #1;
    d = 64'h9E37_79B9_7F4A_7C15;
    data_in = d;
    len = LEN_W'(3);
    mode = 2'b10;
    repeat (5 * SPS + 2) @(posedge clk);
    push_frame(d, 3, 2, $time);
    #1 start = 1'b0;
    wait_idle();

    // Reset mid-frame at sample 300
    popped = 0;
    send({$urandom, $urandom}, 64, $urandom_range(0, 3));
    n = 0;
    while (popped < 300 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("reached_sample_300", popped, 300);
    #2 reset = 1'b0;
    #1;
    flush();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", sample_valid, 0);
    check("abort_mod_out", mod_out, 0);
    check("abort_in_data", in_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send(64'hDEAD_BEEF_CAFE_F00D, 6, 1);
    wait_idle();

    // Randomised frames
    for (int i = 0; i < 10; i++) begin
      send({$urandom, $urandom}, $urandom_range(0, 72), $urandom_range(0, 3));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
